v810_bus_ctl: RTL and testbench
===============================

// Module: v810_bus_ctl
// PURPOSE
//  Sequences and shares the single V810 external bus between two pipeline
//  requesters: instruction fetch (IF, 16-bit reads) and data memory (MEM,
//  32-bit reads/writes with byte enables). Runs arbitration and the T1/T2
//  bus-cycle FSM, and drives the core's IA/ID/DA/DD pins. Acks stall/release the pipe.
// PARAMETERS
//  DATA_RUN_MAX  2    max consecutive MEM grants while IF pending (>=1)
//  TIMEOUT       255  T2 wait states before forced abort; 0 = never abort
// PORTS
//  CLK       in   1   system clock
//  RESn      in   1   reset, asynchronous, active-low
//  CE        in   1   global clock enable; all state advances only when CE=1
//  if_req    in   1   IF request; held until if_ack
//  if_a      in   32  IF byte address (bit 0 ignored)
//  if_ack    out  1   one-CE-cycle completion pulse for IF
//  if_d      out  16  fetched halfword, valid with if_ack
//  dm_req    in   1   MEM request; held until dm_ack
//  dm_we     in   1   1=write, 0=read
//  dm_a      in   32  MEM byte address (bits 1:0 ignored)
//  dm_be     in   4   active-high byte enables
//  dm_wd     in   32  write data
//  dm_ack    out  1   one-CE-cycle completion pulse for MEM
//  dm_rd     out  32  read data, valid with dm_ack
//  bus_err   out  1   one-CE-cycle pulse with ack when cycle aborted by timeout
//  A         out  32  bus address ({addr[31:2],2'b00})
//  D_I       in   32  bus read data
//  D_O       out  32  bus write data
//  D_OE      out  1   bus data output enable
//  BEn       out  4   byte enables, active-low
//  ST        out  2   status: 00 idle, 11 instruction fetch, 01 data access
//  DAn       out  1   data strobe, low in T1 and T2
//  MRQn      out  1   memory request, low for the whole bus cycle
//  RW        out  1   1=read, 0=write
//  BCYSTn    out  1   bus cycle start, low in T1 only
//  READYn    in   1   slave ready, active-low, sampled in T2
// BEHAVIOUR
//  Reset: FSM=IDLE; A=0, D_O=0, D_OE=0, BEn=4'hF, ST=00, DAn=1, MRQn=1,
//   RW=1, BCYSTn=1; all acks/bus_err=0; data-run counter=0. Async assert
//   mid-cycle abandons the cycle without ack; requesters must re-request.
//  FSM: IDLE -> T1 when any req; T1 -> T2 always; T2 stays while READYn=1;
//   T2 -> T1 (back-to-back, no idle) if a req is pending at completion, else IDLE.
//  Arbitration at each IDLE->T1 / T2->T1: MEM wins unless IF pending and
//   data-run counter == DATA_RUN_MAX; then IF wins. Counter++ on MEM grant
//   while if_req=1; cleared on any IF grant or when if_req=0.
//  Grant latches addr/we/be/wd into internal regs at entry to T1; later
//   changes on request inputs are ignored until ack.
//  IF cycle: ST=11, RW=1, BEn = if_a[1] ? 4'b0011 : 4'b1100;
//   if_d = if_a[1] ? D_I[31:16] : D_I[15:0].
//  MEM cycle: ST=01, RW=~dm_we, BEn=~dm_be; writes drive D_O=dm_wd and
//   D_OE=1 in T1 and T2; reads D_OE=0. be=0000 still runs a full cycle.
//  Completion: READYn=0 in T2 -> ack pulses in next CE cycle with data
//   captured from D_I at that edge. Minimum latency req->ack = 3 CE cycles
//   (grant edge, T1, T2); each wait state adds one.
//  Timeout: counter counts T2 cycles with READYn=1; reaching TIMEOUT ends the
//   cycle as if ready, with ack + bus_err, read data = 32'hFFFF_FFFF.
//  Simultaneous if_req and dm_req from IDLE: MEM granted first.
//  CE=0: all outputs and state hold; ack pulses stretch over CE=0 cycles.
// TESTING
//  1 Reset mid-T2 of MEM read -> outputs at reset values at once, no dm_ack.
//  2 IF read a=0x100, READYn=0 first T2, D_I=0xBEEF1234 -> ST=11, BEn=1100,
//    if_d=0x1234 after 3 cycles; a=0x102 -> BEn=0011, if_d=0xBEEF.
//  3 MEM write a=0x2000, be=0101, wd=0xA5A5A5A5, 2 wait states -> RW=0,
//    BEn=1010, D_OE=1 in T1..T2, dm_ack 5 cycles after grant.
//  4 if_req and dm_req both held, DATA_RUN_MAX=2 -> grant order MEM,MEM,IF,
//    MEM,MEM,IF with BCYSTn low every 2nd cycle (no idle gaps).
//  5 TIMEOUT=4, READYn stuck 1 on MEM read -> ack+bus_err after 4 T2s,
//    dm_rd=0xFFFFFFFF, FSM returns IDLE.
//  6 CE toggled 1/0 during #2 -> identical sequence, stretched 2x.

Source files
------------

// File: rtl/v810_bus_ctl.sv
// v810_bus_ctl
//   Shares the V810 external bus between the instruction-fetch requester
//   (IF, 16-bit reads) and the data-memory requester (MEM, 32-bit reads and
//   writes with byte enables). It arbitrates, runs the T1/T2 bus-cycle FSM
//   and drives the bus pins.
//
// Ports
//   CLK, RESn, CE          clock, async active-low reset, global clock enable
//   if_req/if_a            IF request and byte address
//   if_ack/if_d            IF completion pulse and fetched halfword
//   dm_req/dm_we/dm_a      MEM request, write flag, byte address
//   dm_be/dm_wd            MEM byte enables (active-high) and write data
//   dm_ack/dm_rd           MEM completion pulse and read data
//   bus_err                pulses with the ack when a cycle timed out
//   A, D_I, D_O, D_OE      bus address, read data, write data, output enable
//   BEn, ST, DAn, MRQn     byte enables (low), status, data strobe, mem request
//   RW, BCYSTn, READYn     read/write, cycle start, slave ready (sampled in T2)
//   fsm_state              current bus FSM state, for observation
//
// Handshake: a requester raises req with stable address/data and keeps it
// high until its ack. The request is latched at the grant edge, so later
// input changes do not affect the running cycle. A req that is still high
// at the edge completing a cycle counts as a new request and can be granted
// at that same edge (back-to-back). The ack is a single CE-cycle pulse; it
// stretches over any CE=0 cycles that follow.
module v810_bus_ctl #(
    parameter int DATA_RUN_MAX = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        if_req,
    input  logic [31:0] if_a,
    output logic        if_ack,
    output logic [15:0] if_d,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_a,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_wd,
    output logic        dm_ack,
    output logic [31:0] dm_rd,
    output logic        bus_err,
    output logic [31:0] A,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    output logic        D_OE,
    output logic [3:0]  BEn,
    output logic [1:0]  ST,
    output logic        DAn,
    output logic        MRQn,
    output logic        RW,
    output logic        BCYSTn,
    input  logic        READYn,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2
    } state_t;

    localparam int RCW = (DATA_RUN_MAX < 1) ? 1 : $clog2(DATA_RUN_MAX + 1);
    localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_n;
    logic [RCW-1:0] run_cnt;
    logic [TW-1:0]  wait_cnt;

    // Latched request of the cycle on the bus.
    logic           own_if;
    logic           we_r;
    logic           hi_r;
    logic [3:0]     ben_r;
    logic [31:0]    a_r;
    logic [31:0]    wd_r;

    logic           timeout_hit;
    logic           done;
    logic           grant;
    logic           grant_if;
    logic           busy;

    // Address bits below the bus granularity are not used.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^{if_a[0], dm_a[1:0]};

    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = (state == S_T2) && READYn && (wait_cnt == TW'(TIMEOUT - 1));
        end
        done     = (state == S_T2) && (!READYn || timeout_hit);
        // MEM wins unless IF has waited through a full run of MEM grants.
        grant_if = if_req && (!dm_req || (run_cnt == RCW'(DATA_RUN_MAX)));
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_n = S_T1;
                    grant   = 1'b1;
                end
            end
            S_T1: state_n = S_T2;
            S_T2: begin
                if (done) begin
                    if (if_req || dm_req) begin
                        state_n = S_T1;
                        grant   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state <= S_IDLE;
        end else if (CE) begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            run_cnt  <= '0;
            wait_cnt <= '0;
            own_if   <= 1'b0;
            we_r     <= 1'b0;
            hi_r     <= 1'b0;
            ben_r    <= 4'hF;
            a_r      <= '0;
            wd_r     <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            bus_err  <= 1'b0;
            if_d     <= '0;
            dm_rd    <= '0;
        end else if (CE) begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= 1'b0;

            if (grant) begin
                own_if <= grant_if;
                we_r   <= !grant_if && dm_we;
                hi_r   <= if_a[1];
                if (grant_if) begin
                    a_r   <= {if_a[31:2], 2'b00};
                    ben_r <= if_a[1] ? 4'b0011 : 4'b1100;
                end else begin
                    a_r   <= {dm_a[31:2], 2'b00};
                    ben_r <= ~dm_be;
                    if (dm_we) begin
                        wd_r <= dm_wd;
                    end
                end
            end

            // Counts T2 cycles that ended without READYn; restarts every cycle.
            if ((state == S_T2) && !done) begin
                wait_cnt <= wait_cnt + TW'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (!if_req) begin
                run_cnt <= '0;
            end else if (grant && grant_if) begin
                run_cnt <= '0;
            end else if (grant) begin
                run_cnt <= run_cnt + RCW'(1);
            end

            if (done) begin
                bus_err <= timeout_hit;
                if (own_if) begin
                    if_ack <= 1'b1;
                    if (timeout_hit) begin
                        if_d <= 16'hFFFF;
                    end else begin
                        if_d <= hi_r ? D_I[31:16] : D_I[15:0];
                    end
                end else begin
                    dm_ack <= 1'b1;
                    dm_rd  <= timeout_hit ? 32'hFFFF_FFFF : D_I;
                end
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign A         = a_r;
    assign D_O       = wd_r;
    assign D_OE      = busy && we_r;
    assign BEn       = busy ? ben_r : 4'hF;
    assign ST        = !busy ? 2'b00 : (own_if ? 2'b11 : 2'b01);
    assign DAn       = !busy;
    assign MRQn      = !busy;
    assign RW        = busy ? !we_r : 1'b1;
    assign BCYSTn    = (state != S_T1);
    assign fsm_state = state;

endmodule

// File: tb/tb_v810_bus_ctl.sv
// Randomized bench for v810_bus_ctl. A transaction-level model turns each
// grant into the list of bus cycles it must produce (one T1, then the T2s
// implied by the wait states the bench slave chose) and checks pins, acks
// and data every clock.
module tb_v810_bus_ctl;
  localparam int RUN_MAX = 2;
  localparam int TMO     = 4;

  logic        CLK = 1'b0;
  logic        RESn, CE;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_a, dm_a, dm_wd, D_I;
  logic [3:0]  dm_be;
  logic        READYn;
  logic        if_ack, dm_ack, bus_err, D_OE, DAn, MRQn, RW, BCYSTn;
  logic [15:0] if_d;
  logic [31:0] dm_rd, A, D_O;
  logic [3:0]  BEn;
  logic [1:0]  ST, fsm_state;

  always #5 CLK = ~CLK;

  v810_bus_ctl #(.DATA_RUN_MAX(RUN_MAX), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE),
    .if_req(if_req), .if_a(if_a), .if_ack(if_ack), .if_d(if_d),
    .dm_req(dm_req), .dm_we(dm_we), .dm_a(dm_a), .dm_be(dm_be), .dm_wd(dm_wd),
    .dm_ack(dm_ack), .dm_rd(dm_rd), .bus_err(bus_err),
    .A(A), .D_I(D_I), .D_O(D_O), .D_OE(D_OE), .BEn(BEn), .ST(ST),
    .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn),
    .fsm_state(fsm_state)
  );

  // One expected bus clock of a granted transaction.
  typedef struct {
    bit          t1;
    bit          is_if;
    bit          last;
    bit          err;
    bit          we;
    bit          hi;
    logic [31:0] a;
    logic [3:0]  ben;
    logic [31:0] wd;
  } cyc_t;

  cyc_t        exp_q[$];
  cyc_t        cur;
  bit          busy;
  int          run;
  bit          ce_prev;
  int          n_checks, n_pass;
  int          raise_pct, keep_pct;
  bit          ce_rand;

  bit          pend_if, pend_dm, pend_err, pend_we;
  logic [31:0] pend_data;
  bit          exp_if_ack, exp_dm_ack, exp_err, exp_we;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic new_if();
    if_req = 1'b1;
    if_a   = $urandom;
  endtask

  task automatic new_dm();
    dm_req = 1'b1;
    dm_we  = 1'($urandom_range(0, 1));
    dm_a   = $urandom;
    dm_be  = 4'($urandom_range(0, 15));
    dm_wd  = $urandom;
  endtask

  // Expand a grant into its bus clocks using the current request inputs.
  task automatic push_cycle(input bit is_if);
    cyc_t c;
    int   w, n;
    c.is_if = is_if;
    c.we    = !is_if && dm_we;
    c.a     = is_if ? {if_a[31:2], 2'b00} : {dm_a[31:2], 2'b00};
    c.hi    = if_a[1];
    c.ben   = is_if ? (if_a[1] ? 4'b0011 : 4'b1100) : ~dm_be;
    c.wd    = dm_wd;
    w = $urandom_range(0, 5);
    n = (w >= TMO) ? TMO : w + 1;
    c.t1 = 1'b1; c.last = 1'b0; c.err = 1'b0;
    exp_q.push_back(c);
    for (int i = 0; i < n; i++) begin
      c.t1   = 1'b0;
      c.last = (i == n - 1);
      c.err  = c.last && (w >= TMO);
      exp_q.push_back(c);
    end
  endtask

  task automatic check_reset_pins();
    check("rst_A", A, 32'h0);
    check("rst_D_O", D_O, 32'h0);
    check("rst_D_OE", D_OE, 1'b0);
    check("rst_BEn", BEn, 4'hF);
    check("rst_ST", ST, 2'b00);
    check("rst_DAn", DAn, 1'b1);
    check("rst_MRQn", MRQn, 1'b1);
    check("rst_RW", RW, 1'b1);
    check("rst_BCYSTn", BCYSTn, 1'b1);
    check("rst_if_ack", if_ack, 1'b0);
    check("rst_dm_ack", dm_ack, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_state", fsm_state, 2'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    busy = 0; run = 0; ce_prev = 1;
    pend_if = 0; pend_dm = 0; pend_err = 0; pend_we = 0; pend_data = '0;
    exp_if_ack = 0; exp_dm_ack = 0; exp_err = 0; exp_we = 0; exp_data = '0;
  endtask

  task automatic step();
    bit ce, gi, gm;
    @(posedge CLK); #1;
    if (ce_prev) begin
      exp_if_ack = pend_if; exp_dm_ack = pend_dm; exp_err = pend_err;
      exp_we = pend_we; exp_data = pend_data;
      pend_if = 0; pend_dm = 0; pend_err = 0;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        busy = 1;
      end else begin
        busy = 0;
      end
    end

    check("if_ack", if_ack, exp_if_ack);
    check("dm_ack", dm_ack, exp_dm_ack);
    check("bus_err", bus_err, exp_err);
    if (exp_if_ack) check("if_d", if_d, exp_data[15:0]);
    if (exp_dm_ack && !exp_we) check("dm_rd", dm_rd, exp_data);
    if (busy) begin
      check("BCYSTn", BCYSTn, !cur.t1);
      check("DAn", DAn, 1'b0);
      check("MRQn", MRQn, 1'b0);
      check("ST", ST, cur.is_if ? 2'b11 : 2'b01);
      check("A", A, cur.a);
      check("BEn", BEn, cur.ben);
      check("RW", RW, !cur.we);
      check("D_OE", D_OE, cur.we);
      if (cur.we) check("D_O", D_O, cur.wd);
    end else begin
      check("idle_BCYSTn", BCYSTn, 1'b1);
      check("idle_DAn", DAn, 1'b1);
      check("idle_MRQn", MRQn, 1'b1);
      check("idle_ST", ST, 2'b00);
      check("idle_BEn", BEn, 4'hF);
      check("idle_RW", RW, 1'b1);
      check("idle_D_OE", D_OE, 1'b0);
    end

    ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    CE = ce;
    if (ce) begin
      D_I    = $urandom;
      READYn = (busy && !cur.t1) ? !(cur.last && !cur.err) : 1'($urandom_range(0, 1));

      if (busy && cur.last) begin
        pend_if  = cur.is_if;
        pend_dm  = !cur.is_if;
        pend_err = cur.err;
        pend_we  = cur.we;
        if (cur.err) pend_data = 32'hFFFF_FFFF;
        else if (cur.is_if) pend_data = cur.hi ? {16'h0, D_I[31:16]} : {16'h0, D_I[15:0]};
        else pend_data = D_I;
        if (cur.is_if) begin
          if ($urandom_range(1, 100) <= keep_pct) new_if(); else if_req = 1'b0;
        end else begin
          if ($urandom_range(1, 100) <= keep_pct) new_dm(); else dm_req = 1'b0;
        end
      end
      if (!if_req && $urandom_range(1, 100) <= raise_pct) new_if();
      if (!dm_req && $urandom_range(1, 100) <= raise_pct) new_dm();

      gi = 0; gm = 0;
      if ((!busy || cur.last) && (if_req || dm_req)) begin
        if (if_req && (!dm_req || run == RUN_MAX)) gi = 1; else gm = 1;
        push_cycle(gi);
      end
      if (!if_req) run = 0;
      else if (gi) run = 0;
      else if (gm) run++;
    end
    ce_prev = ce;
  endtask

  // Run until a MEM read sits in a non-final T2, then reset asynchronously.
  task automatic mid_reset();
    int guard = 0;
    while (!(busy && !cur.t1 && !cur.is_if && !cur.we && !cur.last) && guard < 400) begin
      step();
      guard++;
    end
    check("reach_mem_t2", guard < 400, 1'b1);
    #2 RESn = 1'b0;
    #1 check_reset_pins();
    if_req = 1'b0; dm_req = 1'b0; CE = 1'b1;
    @(posedge CLK); #1;
    check_reset_pins();
    RESn = 1'b1;
    model_reset();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    RESn = 1'b0; CE = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_a = '0; dm_a = '0; dm_be = '0; dm_wd = '0; D_I = '0; READYn = 1'b1;
    ce_rand = 0;
    repeat (3) @(posedge CLK);
    #1 check_reset_pins();
    RESn = 1'b1;
    model_reset();

    raise_pct = 30;  keep_pct = 50;  ce_rand = 0; repeat (400) step();
    raise_pct = 100; keep_pct = 100;              repeat (150) step();
    mid_reset();
    raise_pct = 40;  keep_pct = 50;  ce_rand = 1; repeat (400) step();
    raise_pct = 100; keep_pct = 100;              repeat (150) step();
    ce_rand = 0; raise_pct = 40; keep_pct = 50;
    mid_reset();
    mid_reset();
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
